// File: rtl/free_reg_list.sv
// -----------------------------------------------------------------------------
// free_reg_list
//   Circular free list of physical register tags sitting between the RRAT and
//   rename. Tags released by the RRAT at commit are pushed at the tail; rename
//   pops up to ALLOC_W tags per cycle from the head. Allocation is
//   all-or-nothing per cycle and follows ascending lane order. A tag that is
//   pushed becomes allocatable on the following cycle; there is no bypass.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   free_valid_in  [FREE_W]       per-lane free strobe from the RRAT
//   free_regs_in   [FREE_W*TW]    per-lane freed tag, lane j at [j*TW +: TW]
//   alloc_req      [ALLOC_W]      rename lane i needs a destination tag
//   alloc_ready    1              enough tags for every requesting lane
//   alloc_valid    [ALLOC_W]      alloc_req gated by alloc_ready
//   alloc_regs     [ALLOC_W*TW]   granted tag per lane, lane i at [i*TW +: TW]
//   free_count     [CW]           registered occupancy
//   overflow_err   1              sticky, a push exceeded capacity
// -----------------------------------------------------------------------------
module free_reg_list #(
   parameter int NUM_PHYS_REGS = 64,
   parameter int NUM_ARCH_REGS = 32,
   parameter int ALLOC_W       = 4,
   parameter int FREE_W        = 2*ALLOC_W+2,
   parameter int TW            = $clog2(NUM_PHYS_REGS),
   parameter int CW            = $clog2(NUM_PHYS_REGS+1)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FREE_W-1:0]      free_valid_in,
   input  logic [FREE_W*TW-1:0]   free_regs_in,
   input  logic [ALLOC_W-1:0]     alloc_req,
   output logic                   alloc_ready,
   output logic [ALLOC_W-1:0]     alloc_valid,
   output logic [ALLOC_W*TW-1:0]  alloc_regs,
   output logic [CW-1:0]          free_count,
   output logic                   overflow_err
);

   // Tags above the architectural range (incl. NZCV) start out free.
   localparam int RESET_CNT = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

   logic [TW-1:0]     fl_r [NUM_PHYS_REGS];
   logic [TW-1:0]     head_r;
   logic [TW-1:0]     tail_r;
   logic [CW-1:0]     count_r;
   logic              overflow_err_r;

   logic [CW-1:0]     n_req_s;
   logic [CW-1:0]     n_grant_s;
   logic [CW-1:0]     rank_s;
   logic              ready_s;
   logic [CW-1:0]     space_s;
   logic [CW-1:0]     acc_s;
   logic              drop_s;
   logic [FREE_W-1:0] wr_en_s;
   logic [TW-1:0]     wr_idx_s [FREE_W];
   logic [CW-1:0]     count_next_s;

   // Pointer advance modulo NUM_PHYS_REGS; the capacity need not be a power
   // of two, so wrap by compare-and-subtract rather than truncation.
   function automatic logic [TW-1:0] ptr_add(input logic [TW-1:0] ptr,
                                             input logic [CW-1:0] inc);
      logic [CW:0] sum_v;
      sum_v = (CW+1)'(ptr) + (CW+1)'(inc);
      if (sum_v >= (CW+1)'(NUM_PHYS_REGS)) begin
         return TW'(sum_v - (CW+1)'(NUM_PHYS_REGS));
      end else begin
         return TW'(sum_v);
      end
   endfunction

   // Allocation: the k-th requesting lane reads the k-th entry past head.
   always_comb begin
      n_req_s    = {CW{1'b0}};
      rank_s     = {CW{1'b0}};
      alloc_regs = {(ALLOC_W*TW){1'b0}};
      for (int i = 0; i < ALLOC_W; i++) begin
         n_req_s = n_req_s + CW'(alloc_req[i]);
      end
      // Only the registered count is used; same-cycle pushes never help.
      ready_s = (count_r >= n_req_s);
      for (int i = 0; i < ALLOC_W; i++) begin
         alloc_regs[i*TW +: TW] = fl_r[ptr_add(head_r, rank_s)];
         rank_s = rank_s + CW'(alloc_req[i]);
      end
      if (ready_s) begin
         n_grant_s = n_req_s;
      end else begin
         n_grant_s = {CW{1'b0}};
      end
   end

   // Free: compact valid lanes onto tail, tail+1, ... while room remains.
   // Room counts the slots vacated by this cycle's grant.
   always_comb begin
      space_s = CW'(NUM_PHYS_REGS) - (count_r - n_grant_s);
      acc_s   = {CW{1'b0}};
      drop_s  = 1'b0;
      wr_en_s = {FREE_W{1'b0}};
      for (int j = 0; j < FREE_W; j++) begin
         wr_idx_s[j] = ptr_add(tail_r, acc_s);
         if (free_valid_in[j]) begin
            if (acc_s < space_s) begin
               wr_en_s[j] = 1'b1;
               acc_s      = acc_s + CW'(1);
            end else begin
               drop_s = 1'b1;
            end
         end else begin
            wr_en_s[j] = 1'b0;
         end
      end
      count_next_s = count_r - n_grant_s + acc_s;
   end

   // List storage, pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_PHYS_REGS; k++) begin
            fl_r[k] <= (k < RESET_CNT) ? TW'(NUM_ARCH_REGS + 1 + k) : {TW{1'b0}};
         end
         head_r         <= {TW{1'b0}};
         tail_r         <= TW'(RESET_CNT);
         count_r        <= CW'(RESET_CNT);
         overflow_err_r <= 1'b0;
      end else begin
         for (int j = 0; j < FREE_W; j++) begin
            if (wr_en_s[j]) begin
               fl_r[wr_idx_s[j]] <= free_regs_in[j*TW +: TW];
            end
         end
         head_r  <= ptr_add(head_r, n_grant_s);
         tail_r  <= ptr_add(tail_r, acc_s);
         count_r <= count_next_s;
         if (drop_s) begin
            overflow_err_r <= 1'b1;
         end
      end
   end

   assign alloc_ready  = ready_s;
   assign alloc_valid  = alloc_req & {ALLOC_W{ready_s}};
   assign free_count   = count_r;
   assign overflow_err = overflow_err_r;

endmodule

// File: tb/tb_free_reg_list.sv
// -----------------------------------------------------------------------------
// tb_free_reg_list
//   Directed checks of free_reg_list (64 phys, 32 arch, 4 alloc lanes,
//   10 free lanes) with hand-computed values, plus a queue reference model
//   for a long mixed push/pop run that wraps the list many times.
// -----------------------------------------------------------------------------
module tb_free_reg_list;

   localparam int NP = 64;
   localparam int NA = 32;
   localparam int AW = 4;
   localparam int FW = 10;
   localparam int TW = 6;
   localparam int CW = 7;

   logic             clk = 1'b0;
   logic             rst;
   logic [FW-1:0]    free_valid_in;
   logic [FW*TW-1:0] free_regs_in;
   logic [AW-1:0]    alloc_req;
   logic             alloc_ready;
   logic [AW-1:0]    alloc_valid;
   logic [AW*TW-1:0] alloc_regs;
   logic [CW-1:0]    free_count;
   logic             overflow_err;

   int total = 0;
   int bad   = 0;
   int q[$];      // model: tags in the list, head first
   int outp[$];   // tags currently held outside the list

   always #5 clk = ~clk;

   free_reg_list #(
      .NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA), .ALLOC_W(AW), .FREE_W(FW)
   ) dut (
      .clk(clk), .rst(rst), .free_valid_in(free_valid_in),
      .free_regs_in(free_regs_in), .alloc_req(alloc_req),
      .alloc_ready(alloc_ready), .alloc_valid(alloc_valid),
      .alloc_regs(alloc_regs), .free_count(free_count),
      .overflow_err(overflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      alloc_req     = '0;
      free_valid_in = '0;
      free_regs_in  = '0;
   endtask

   task automatic set_free(input int lane, input int tag);
      free_valid_in[lane]          = 1'b1;
      free_regs_in[lane*TW +: TW]  = TW'(tag);
   endtask

   function automatic int lane_tag(input int i);
      return int'(alloc_regs[i*TW +: TW]);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      step();
      rst = 1'b0;
      q.delete();
      outp.delete();
      for (int t = 0; t < NP; t++) begin
         if (t > NA) q.push_back(t);
         else        outp.push_back(t);
      end
   endtask

   initial begin
      int          n;
      int          k;
      int          idx;
      int          found;
      logic [3:0]  req;
      bit          ready_e;
      int          pend[$];

      // 1: reset state and a full-width grant
      rst = 1'b1;
      clear_in();
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_count", free_count, 31);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_ready_idle", alloc_ready, 1);
      alloc_req = 4'b1111;
      #1;
      chk("t1_ready", alloc_ready, 1);
      chk("t1_valid", alloc_valid, 4'b1111);
      chk("t1_l0", lane_tag(0), 33);
      chk("t1_l1", lane_tag(1), 34);
      chk("t1_l2", lane_tag(2), 35);
      chk("t1_l3", lane_tag(3), 36);
      step();
      alloc_req = 4'b0000;
      #1;
      chk("t1_count", free_count, 27);

      // 2: sparse request, lanes compacted
      do_reset();
      alloc_req = 4'b1010;
      #1;
      chk("t2_valid", alloc_valid, 4'b1010);
      chk("t2_l1", lane_tag(1), 33);
      chk("t2_l3", lane_tag(3), 34);
      step();
      alloc_req = 4'b0001;
      #1;
      chk("t2_next_l0", lane_tag(0), 35);
      step();
      alloc_req = 4'b0000;
      #1;
      chk("t2_count", free_count, 28);

      // 3: stall at count=2, same-cycle push not usable
      repeat (6) begin
         alloc_req = 4'b1111;
         step();
      end
      alloc_req = 4'b0011;
      step();
      alloc_req = 4'b0000;
      #1;
      chk("t3_count2", free_count, 2);
      alloc_req = 4'b0111;
      set_free(0, 7);
      set_free(5, 9);
      #1;
      chk("t3_stall_ready", alloc_ready, 0);
      chk("t3_stall_valid", alloc_valid, 0);
      step();
      clear_in();
      #1;
      chk("t3_count4", free_count, 4);
      alloc_req = 4'b0111;
      #1;
      chk("t3_ready", alloc_ready, 1);
      chk("t3_l0", lane_tag(0), 62);
      chk("t3_l1", lane_tag(1), 63);
      chk("t3_l2", lane_tag(2), 7);
      step();
      alloc_req = 4'b0001;
      #1;
      chk("t3_last", lane_tag(0), 9);
      step();
      #1;
      chk("t3_empty_count", free_count, 0);
      chk("t3_empty_ready", alloc_ready, 0);
      chk("t3_empty_valid", alloc_valid, 0);
      alloc_req = 4'b0000;
      #1;
      chk("t3_empty_idle_ready", alloc_ready, 1);

      // 4: mixed random traffic against the queue model
      q.delete();
      outp.delete();
      for (int t = 0; t < NP; t++) outp.push_back(t);
      for (int c = 0; c < 1000; c++) begin
         clear_in();
         pend.delete();
         req = 4'($urandom_range(0, 15));
         alloc_req = req;
         for (int j = 0; j < FW; j++) begin
            if ($urandom_range(0, (c % 200 < 100) ? 5 : 2) == 0 && outp.size() > 0) begin
               idx = $urandom_range(0, outp.size() - 1);
               set_free(j, outp[idx]);
               pend.push_back(outp[idx]);
               outp.delete(idx);
            end
         end
         #1;
         n = $countones(req);
         ready_e = (q.size() >= n);
         chk("r_ready", alloc_ready, ready_e);
         chk("r_valid", alloc_valid, ready_e ? req : 4'b0000);
         if (ready_e) begin
            k = 0;
            for (int i = 0; i < AW; i++) begin
               if (req[i]) begin
                  chk("r_tag", lane_tag(i), q[k]);
                  k++;
               end
            end
         end
         step();
         if (ready_e) begin
            for (int i = 0; i < n; i++) begin
               found = 0;
               foreach (outp[m]) if (outp[m] == q[0]) found = 1;
               chk("r_dup", found, 0);
               outp.push_back(q.pop_front());
            end
         end
         foreach (pend[p]) q.push_back(pend[p]);
         chk("r_count", free_count, q.size());
      end

      // 5: fill to capacity, then overflow
      clear_in();
      while (outp.size() > 0) begin
         clear_in();
         for (int j = 0; j < FW && outp.size() > 0; j++) begin
            idx = outp.pop_front();
            set_free(j, idx);
            q.push_back(idx);
         end
         step();
      end
      clear_in();
      #1;
      chk("t5_full", free_count, 64);
      chk("t5_ovf_pre", overflow_err, 0);
      set_free(0, 3);
      step();
      clear_in();
      #1;
      chk("t5_ovf", overflow_err, 1);
      chk("t5_count", free_count, 64);
      step();
      chk("t5_ovf_hold", overflow_err, 1);
      alloc_req = 4'b1111;
      #1;
      for (int i = 0; i < AW; i++) chk("t5_tag", lane_tag(i), q[i]);
      step();
      for (int i = 0; i < AW; i++) outp.push_back(q.pop_front());
      clear_in();
      #1;
      chk("t5_count60", free_count, 60);
      // six lanes offered into four slots: lowest four accepted
      for (int j = 0; j < 4; j++) set_free(j, outp[j]);
      set_free(4, 1);
      set_free(5, 2);
      step();
      for (int j = 0; j < 4; j++) q.push_back(outp.pop_front());
      clear_in();
      #1;
      chk("t5_partial", free_count, 64);
      chk("t5_ovf_still", overflow_err, 1);

      // 6: reset in the middle of a push+pop burst
      alloc_req = 4'b1111;
      for (int j = 0; j < FW; j++) set_free(j, j);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_in();
      alloc_req = 4'b0001;
      #1;
      chk("t6_count", free_count, 31);
      chk("t6_first", lane_tag(0), 33);
      chk("t6_ovf", overflow_err, 0);
      chk("t6_ready", alloc_ready, 1);
      step();
      clear_in();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
